// File: rtl/core_store_unit_pkg.sv
// core_store_unit_pkg
// Shared defines for the load/store units: funct3 encodings for loads and
// stores, the store FSM state encoding and a couple of small helpers used
// when decoding a store request.
// No ports (package).

package core_store_unit_pkg;

    localparam int LANES = 4;

    // Load funct3 encodings (shared with the load unit)
    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] STORE_SB = 3'b000;
    localparam logic [2:0] STORE_SH = 3'b001;
    localparam logic [2:0] STORE_SW = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ1  = 3'd1,
        ST_RESP1 = 3'd2,
        ST_REQ2  = 3'd3,
        ST_RESP2 = 3'd4
    } store_state_e;

    // Unshifted byte-lane mask for a store size; zero marks an illegal funct3.
    function automatic logic [LANES-1:0] store_base_mask(input logic [2:0] op);
        logic [LANES-1:0] m;
        case (op)
            STORE_SB: m = 4'b0001;
            STORE_SH: m = 4'b0011;
            STORE_SW: m = 4'b1111;
            default:  m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic store_op_legal(input logic [2:0] op);
        return (store_base_mask(op) != 4'b0000);
    endfunction

endpackage

// File: rtl/core_store_unit_lane_gen.sv
// core_store_lane_gen
// Combinational byte-lane generation for a store: builds the 7-bit lane
// mask (base mask shifted by the byte offset; bits [6:4] spill into the next
// word) and the lane-aligned write data (replicated value rotated left by
// one lane per byte of offset).
// Ports:
//   op        in   store funct3
//   offset    in   byte offset within the word (addr[1:0])
//   wdata     in   raw store data (rs2)
//   mask      out  7-bit lane mask, [3:0] first word, [6:4] second word
//   wdata_rot out  replicated and rotated write data

module core_store_lane_gen
    import core_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            op,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [6:0]            mask,
    output logic [DATA_WIDTH-1:0] wdata_rot
);

    localparam int LANE_W = DATA_WIDTH / LANES;

    logic [DATA_WIDTH-1:0] rep;

    always_comb begin
        case (op)
            STORE_SB: rep = {4{wdata[LANE_W-1:0]}};
            STORE_SH: rep = {2{wdata[2*LANE_W-1:0]}};
            default:  rep = wdata;
        endcase
    end

    // Rotation keeps the replicated copies intact, so for SB/SH every lane
    // already holds the right bytes; only the byte enables pick them.
    always_comb begin
        case (offset)
            2'd1:    wdata_rot = {rep[DATA_WIDTH-LANE_W-1:0],   rep[DATA_WIDTH-1:DATA_WIDTH-LANE_W]};
            2'd2:    wdata_rot = {rep[DATA_WIDTH-2*LANE_W-1:0], rep[DATA_WIDTH-1:DATA_WIDTH-2*LANE_W]};
            2'd3:    wdata_rot = {rep[LANE_W-1:0],              rep[DATA_WIDTH-1:LANE_W]};
            default: wdata_rot = rep;
        endcase
    end

    assign mask = {3'b000, store_base_mask(op)} << offset;

endmodule

// File: rtl/core_store_unit.sv
// core_store_unit
// Store unit between the pipeline and a req/gnt/rvalid data memory port.
// Accepts SB/SH/SW in IDLE, issues one registered write request (two when a
// misaligned store is split) and pulses store_done_o on the final response.
// Optional build macro:
//   STORE_MISALIGNED_SPLIT_EN  split a word-crossing store into two accesses;
//                              when undefined such a store raises a one-cycle
//                              store_misaligned_o pulse and issues nothing.
// Ports:
//   clk_i, rstn_i        clock, async active-low reset
//   m_store_valid_i      store request present (held while busy)
//   m_STORE_op_i         funct3 (SB/SH/SW)
//   m_addr_i, m_wdata_i  byte address, rs2 value
//   store_busy_o         stall the pipeline
//   store_done_o         one-cycle completion pulse
//   store_misaligned_o   one-cycle misaligned-fault pulse
//   data_req_o/gnt_i/rvalid_i/we_o/be_o/addr_o/wdata_o  memory port
//
// state    | meaning
// ---------+------------------------------------------------
// IDLE     | waiting for a store; inputs sampled only here
// REQ1     | first (or only) access requested, awaiting gnt
// RESP1    | first access granted, awaiting rvalid
// REQ2     | second access of a split store, awaiting gnt
// RESP2    | second access granted, awaiting rvalid

module core_store_unit
    import core_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  m_store_valid_i,
    input  logic [2:0]            m_STORE_op_i,
    input  logic [DATA_WIDTH-1:0] m_addr_i,
    input  logic [DATA_WIDTH-1:0] m_wdata_i,
    output logic                  store_busy_o,
    output logic                  store_done_o,
    output logic                  store_misaligned_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [DATA_WIDTH-1:0] data_addr_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o
);

`ifdef STORE_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    store_state_e state_q, state_d;

    logic [6:0]            lane_mask;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic                  op_legal;
    logic                  misaligned;

    logic                  req_d;
    logic [3:0]            be_d;
    logic [DATA_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  done_d;
    logic                  mis_d;

`ifdef STORE_MISALIGNED_SPLIT_EN
    logic [2:0]            be_hi_q, be_hi_d;
`endif

    core_store_lane_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_gen (
        .op        (m_STORE_op_i),
        .offset    (m_addr_i[1:0]),
        .wdata     (m_wdata_i),
        .mask      (lane_mask),
        .wdata_rot (lane_wdata)
    );

    assign op_legal   = store_op_legal(m_STORE_op_i);
    assign misaligned = |lane_mask[6:4];

    // Gated by rstn_i so the stall drops immediately while reset is asserted.
    assign store_busy_o = rstn_i &&
                          ((state_q != ST_IDLE) ||
                           (m_store_valid_i && op_legal && (!misaligned || SPLIT_EN)));

    assign data_we_o = data_req_o;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = data_req_o;
        be_d    = data_be_o;
        addr_d  = data_addr_o;
        wdata_d = data_wdata_o;
        done_d  = 1'b0;
        mis_d   = 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
        be_hi_d = be_hi_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m_store_valid_i && op_legal) begin
                    if (misaligned && !SPLIT_EN) begin
                        mis_d = 1'b1;
                    end else begin
                        state_d = ST_REQ1;
                        req_d   = 1'b1;
                        be_d    = lane_mask[3:0];
                        addr_d  = {m_addr_i[DATA_WIDTH-1:2], 2'b00};
                        wdata_d = lane_wdata;
`ifdef STORE_MISALIGNED_SPLIT_EN
                        be_hi_d = lane_mask[6:4];
`endif
                    end
                end
            end
            ST_REQ1: begin
                if (data_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = ST_RESP1;
                end
            end
            ST_RESP1: begin
                if (data_rvalid_i) begin
`ifdef STORE_MISALIGNED_SPLIT_EN
                    if (be_hi_q != 3'b000) begin
                        // Same rotated data; the high lanes land in the next word.
                        state_d = ST_REQ2;
                        req_d   = 1'b1;
                        be_d    = {1'b0, be_hi_q};
                        addr_d  = data_addr_o + DATA_WIDTH'(4);
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
`else
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef STORE_MISALIGNED_SPLIT_EN
            ST_REQ2: begin
                if (data_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = ST_RESP2;
                end
            end
            ST_RESP2: begin
                if (data_rvalid_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_req_o         <= 1'b0;
            data_be_o          <= 4'b0000;
            data_addr_o        <= '0;
            data_wdata_o       <= '0;
            store_done_o       <= 1'b0;
            store_misaligned_o <= 1'b0;
        end else begin
            data_req_o         <= req_d;
            data_be_o          <= be_d;
            data_addr_o        <= addr_d;
            data_wdata_o       <= wdata_d;
            store_done_o       <= done_d;
            store_misaligned_o <= mis_d;
        end
    end

`ifdef STORE_MISALIGNED_SPLIT_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            be_hi_q <= 3'b000;
        end else begin
            be_hi_q <= be_hi_d;
        end
    end
`endif

endmodule

// File: tb/tb_core_store_unit.sv
// tb_core_store_unit
// Directed and randomized checks of core_store_unit against a byte-level
// reference model. Build with or without STORE_MISALIGNED_SPLIT_EN; the
// expectations follow the same macro.

module tb_core_store_unit;

`ifdef STORE_MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  op_i = 3'b000;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic        busy, done, mis_o, req, we;
    logic [3:0]  be;
    logic [31:0] addr_o, wdata_o;

    int compared = 0;
    int mismatched = 0;

    core_store_unit #(.DATA_WIDTH(32)) dut (
        .clk_i              (clk),
        .rstn_i             (rstn),
        .m_store_valid_i    (valid),
        .m_STORE_op_i       (op_i),
        .m_addr_i           (addr_i),
        .m_wdata_i          (wdata_i),
        .store_busy_o       (busy),
        .store_done_o       (done),
        .store_misaligned_o (mis_o),
        .data_req_o         (req),
        .data_gnt_i         (gnt),
        .data_rvalid_i      (rvalid),
        .data_we_o          (we),
        .data_be_o          (be),
        .data_addr_o        (addr_o),
        .data_wdata_o       (wdata_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: which bytes land where, computed byte by byte.
    task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                         output bit legal, output bit mis,
                         output logic [31:0] a0, output logic [31:0] a1,
                         output logic [3:0] be0, output logic [3:0] be1,
                         output logic [31:0] wd);
        int size;
        int off;
        size = (op == 3'd0) ? 1 : (op == 3'd1) ? 2 : (op == 3'd2) ? 4 : 0;
        off  = int'(addr % 4);
        legal = (size != 0);
        mis   = legal && (off + size > 4);
        be0 = 4'b0000;
        be1 = 4'b0000;
        for (int b = 0; b < size; b++) begin
            if (off + b < 4) be0[off + b] = 1'b1;
            else             be1[off + b - 4] = 1'b1;
        end
        a0 = addr - (addr % 4);
        a1 = a0 + 32'd4;
        wd = '0;
        for (int l = 0; l < 4; l++) begin
            int idx;
            idx = size == 0 ? 0 : ((l - off + 4) % 4) % size;
            wd[8*l +: 8] = data[8*idx +: 8];
        end
    endtask

    task automatic run_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                             input int gdly, input int rdly);
        bit          legal, mis;
        logic [31:0] a0, a1, wd, exp_a;
        logic [3:0]  be0, be1, exp_be;
        int          n, lat;
        model(op, addr, data, legal, mis, a0, a1, be0, be1, wd);
        n = mis ? 2 : 1;

        @(negedge clk);
        valid = 1'b1; op_i = op; addr_i = addr; wdata_i = data;
        #1;
        check("busy_on_offer", busy, 32'(legal && (!mis || SPLIT)));

        if (!legal) begin
            @(negedge clk);
            check("illegal_no_req", req, 0);
            check("illegal_no_fault", mis_o, 0);
            check("illegal_busy", busy, 0);
            valid = 1'b0;
            @(negedge clk);
            check("illegal_no_done", done, 0);
            check("illegal_no_req2", req, 0);
            return;
        end

        if (mis && !SPLIT) begin
            @(negedge clk);
            check("mis_pulse", mis_o, 1);
            check("mis_no_req", req, 0);
            check("mis_busy", busy, 0);
            valid = 1'b0;
            @(negedge clk);
            check("mis_pulse_end", mis_o, 0);
            check("mis_no_done", done, 0);
            check("mis_no_req2", req, 0);
            return;
        end

        lat = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            lat++;
            if (k == 0) begin
                // The unit must not resample outside IDLE.
                op_i = 3'($urandom); addr_i = $urandom; wdata_i = $urandom;
            end
            exp_a  = (k == 0) ? a0 : a1;
            exp_be = (k == 0) ? be0 : be1;
            rvalid = 1'b0;
            check("req_rise", req, 1);
            check("we_eq_req", we, 1);
            check("addr", addr_o, exp_a);
            check("be", be, 32'(exp_be));
            check("wdata", wdata_o, wd);
            check("busy_txn", busy, 1);
            check("no_early_done", done, 0);
            for (int g = 0; g < gdly; g++) begin
                rvalid = 1'($urandom_range(0, 1));
                @(negedge clk);
                lat++;
                check("req_hold", req, 1);
                check("addr_hold", addr_o, exp_a);
                check("be_hold", be, 32'(exp_be));
                check("wdata_hold", wdata_o, wd);
                check("stray_rvalid_done", done, 0);
            end
            rvalid = 1'b0;
            gnt = 1'b1;
            @(negedge clk);
            lat++;
            gnt = 1'b0;
            check("req_drop", req, 0);
            check("we_drop", we, 0);
            check("resp_no_done", done, 0);
            for (int r = 0; r < rdly; r++) begin
                @(negedge clk);
                lat++;
                check("resp_wait_req", req, 0);
                check("resp_wait_done", done, 0);
            end
            rvalid = 1'b1;
            if (k == n - 1) valid = 1'b0;
        end
        @(negedge clk);
        lat++;
        rvalid = 1'b0;
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_req", req, 0);
        check("latency", 32'(lat), 32'(n * (2 + gdly + rdly) + 1));
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    task automatic reset_mid_txn();
        @(negedge clk);
        valid = 1'b1; op_i = 3'b010; addr_i = 32'h0000_0300; wdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        valid = 1'b0;
        check("rst_pre_req", req, 1);
        @(negedge clk);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_req", req, 0);
        check("rst_we", we, 0);
        check("rst_be", be, 0);
        check("rst_addr", addr_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rstn = 1'b1;
        rvalid = 1'b1;
        @(negedge clk);
        rvalid = 1'b0;
        check("late_rvalid_done", done, 0);
        check("late_rvalid_req", req, 0);
        @(negedge clk);
        check("late_rvalid_done2", done, 0);
        check("late_rvalid_busy", busy, 0);
    endtask

    initial begin
        valid = 1'b1; op_i = 3'b010; addr_i = 32'h0000_0100;
        #2;
        rstn = 1'b0;
        #1;
        check("reset_req", req, 0);
        check("reset_be", be, 0);
        check("reset_addr", addr_o, 0);
        check("reset_wdata", wdata_o, 0);
        check("reset_done", done, 0);
        check("reset_mis", mis_o, 0);
        check("reset_busy", busy, 0);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        run_store(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0);
        run_store(3'b000, 32'h0000_0203, 32'h0000_00A5, 4, 1);
        run_store(3'b001, 32'h0000_0102, 32'h0000_1234, 1, 0);
        run_store(3'b010, 32'h0000_0101, 32'h1122_3344, 0, 1);
        run_store(3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 2, 2);
        run_store(3'b011, 32'h0000_0100, 32'h5555_5555, 0, 0);
        run_store(3'b111, 32'h0000_0104, 32'h6666_6666, 0, 0);
        reset_mid_txn();

        for (int i = 0; i < 40; i++) begin
            run_store(3'($urandom_range(0, 4)), $urandom, $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
